// File: rtl/bcd_press_display.sv
// Counts debounced button presses in a 4-digit BCD counter and scans the count
// onto a multiplexed common-anode seven-segment display.
module bcd_press_display #(
  parameter int SCAN_DIV = 5000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        MHz,
  input  logic        rst,
  input  logic        nb,
  output logic [15:0] value,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic             wrap_q, wrap_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             press;
  logic             carry;
  logic             tick;
  logic [3:0]       blank;

  always_comb begin
    s1_d   = nb;
    s2_d   = s1_q;
    prev_d = s2_q;
    press  = s2_q & ~prev_q;

    // Ripple the increment through the digits; a carry out of the top digit is the wrap.
    digit_d = digit_q;
    carry   = press;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (digit_q[k] == 4'd9) begin
          digit_d[k] = 4'd0;
        end else begin
          digit_d[k] = digit_q[k] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    wrap_d = carry;

    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);

    blank = 4'b0000;
    if (BLANK_LZ) begin
      blank[3] = (digit_q[3] == 4'd0);
      blank[2] = blank[3] && (digit_q[2] == 4'd0);
      blank[1] = blank[2] && (digit_q[1] == 4'd0);
    end

    // idx_q names the digit shown at the next tick, so the first tick shows digit 0.
    an_d  = an_q;
    seg_d = seg_q;
    idx_d = idx_q;
    if (tick) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank[idx_q] ? 8'hFF : {1'b1, enc(digit_q[idx_q])};
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge MHz) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      digit_q <= '0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign value = digit_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_press_display.sv
// Directed bench for bcd_press_display with a fast scan (SCAN_DIV=4); a second
// instance with leading-zero blanking disabled shares the same inputs.
module tb_bcd_press_display;

  logic        MHz = 1'b0;
  logic        rst = 1'b1;
  logic        nb  = 1'b0;
  logic [15:0] value, value_nb;
  logic        wrap, wrap_nb;
  logic [3:0]  an, an_nb;
  logic [7:0]  seg, seg_nb;

  int check_count = 0;
  int pass_count  = 0;
  bit bad_nibble  = 1'b0;
  bit bad_an      = 1'b0;

  always #5 MHz = ~MHz;

  bcd_press_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .MHz(MHz), .rst(rst), .nb(nb),
    .value(value), .wrap(wrap), .an(an), .seg(seg)
  );

  bcd_press_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .MHz(MHz), .rst(rst), .nb(nb),
    .value(value_nb), .wrap(wrap_nb), .an(an_nb), .seg(seg_nb)
  );

  // Continuous legality watch: BCD digits only, never more than one anode lit.
  always @(negedge MHz) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++)
        if (value[4*k +: 4] > 4'd9) bad_nibble = 1'b1;
      if (an != 4'b1111 && $countones(~an) != 1) bad_an = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge MHz);
  endtask

  // n full presses; each press completes (value updated) before the task returns.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      nb = 1'b1;
      wait_cycles(2);
      nb = 1'b0;
      wait_cycles(2);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wait_cycles(n);
    rst = 1'b0;
  endtask

  // Stops at the first negedge of a slot whose anode pattern equals target.
  task automatic align_slot(input logic [3:0] target, output bit found);
    int i;
    found = 1'b0;
    i = 0;
    while (an == target && i < 40) begin
      @(negedge MHz);
      i++;
    end
    while (!found && i < 40) begin
      @(negedge MHz);
      i++;
      if (an == target) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    logic [3:0] exp_an [4];
    logic [7:0] exp_seg [4];
    logic [7:0] exp_seg_nb [4];
    exp_an     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg    = '{8'hA4, 8'h99, 8'hFF, 8'hFF};
    exp_seg_nb = '{8'hA4, 8'h99, 8'hC0, 8'hC0};

    // Reset state and first tick
    wait_cycles(3);
    checkOutput("rst_value", value, 16'h0000);
    checkOutput("rst_wrap", wrap, 1'b0);
    checkOutput("rst_an", an, 4'b1111);
    checkOutput("rst_seg", seg, 8'hFF);
    rst = 1'b0;
    wait_cycles(3);
    checkOutput("dark_before_tick", an, 4'b1111);
    wait_cycles(1);
    checkOutput("first_tick_an", an, 4'b1110);
    checkOutput("first_tick_seg", seg, 8'hC0);
    checkOutput("first_tick_seg_nb", seg_nb, 8'hC0);

    // Latency: nb rises mid-cycle, value changes on the third following edge
    nb = 1'b1;
    wait_cycles(2);
    checkOutput("latency_edge2", value, 16'h0000);
    wait_cycles(1);
    checkOutput("latency_edge3", value, 16'h0001);
    wait_cycles(47);
    checkOutput("level_held_once", value, 16'h0001);
    nb = 1'b0;
    wait_cycles(6);
    checkOutput("falling_no_action", value, 16'h0001);
    checkOutput("no_wrap_small", wrap, 1'b0);

    // Carry chain
    do_reset(2);
    applyStimulus(10);
    checkOutput("carry_10", value, 16'h0010);
    applyStimulus(90);
    checkOutput("carry_100", value, 16'h0100);
    checkOutput("carry_100_nb", value_nb, 16'h0100);

    // Wrap from 9999
    applyStimulus(9899);
    checkOutput("preload_9999", value, 16'h9999);
    nb = 1'b1;
    wait_cycles(2);
    checkOutput("pre_wrap_value", value, 16'h9999);
    checkOutput("pre_wrap_pulse", wrap, 1'b0);
    nb = 1'b0;
    wait_cycles(1);
    checkOutput("wrap_value", value, 16'h0000);
    checkOutput("wrap_pulse", wrap, 1'b1);
    wait_cycles(1);
    checkOutput("wrap_one_cycle", wrap, 1'b0);
    checkOutput("after_wrap_value", value, 16'h0000);

    // Scan and blanking at 0042
    do_reset(2);
    applyStimulus(42);
    checkOutput("value_42", value, 16'h0042);
    wait_cycles(16);
    align_slot(4'b1110, found);
    checkOutput("scan_align", found, 1'b1);
    for (int s = 0; s < 4; s++) begin
      checkOutput($sformatf("scan_an_%0d", s), an, exp_an[s]);
      checkOutput($sformatf("scan_seg_%0d", s), seg, exp_seg[s]);
      checkOutput($sformatf("scan_seg_nb_%0d", s), seg_nb, exp_seg_nb[s]);
      wait_cycles(2);
      checkOutput($sformatf("scan_hold_%0d", s), an, exp_an[s]);
      wait_cycles(2);
    end

    // Reset in the middle of digit 2's slot, with a press pulse that never survives rst
    do_reset(2);
    applyStimulus(123);
    checkOutput("value_123", value, 16'h0123);
    wait_cycles(16);
    align_slot(4'b1011, found);
    checkOutput("mid_align", found, 1'b1);
    checkOutput("mid_seg_d2", seg, 8'hF9);
    rst = 1'b1;
    nb  = 1'b1;
    wait_cycles(1);
    checkOutput("mid_rst_value", value, 16'h0000);
    checkOutput("mid_rst_wrap", wrap, 1'b0);
    checkOutput("mid_rst_an", an, 4'b1111);
    checkOutput("mid_rst_seg", seg, 8'hFF);
    nb = 1'b0;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(3);
    checkOutput("mid_dark", an, 4'b1111);
    wait_cycles(1);
    checkOutput("mid_restart_an", an, 4'b1110);
    checkOutput("mid_restart_seg", seg, 8'hC0);
    wait_cycles(6);
    checkOutput("press_in_rst_ignored", value, 16'h0000);

    checkOutput("nibble_range", bad_nibble, 1'b0);
    checkOutput("an_onehot", bad_an, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
